// File: rtl/exmem_stage.sv
// exmem_stage
// -----------
// EX/MEM pipeline stage for the RISC-V core. It carries the branch-target
// adder result, ALU result, zero flag, store data, destination register and
// the memory/writeback control bundle from EX to MEM. The stage has a
// valid/ready handshake and a one-entry skid buffer. MEM-side back-pressure
// never drops an instruction, and in_ready comes straight from a flop.
//
// Optional feature: define EXMEM_STAGE_STATS_EN to add the stall and flush
// event counters (stall_cnt, flush_cnt).
//
// Ports
//   clk, reset            clock; synchronous active-high reset
//   flush                 synchronous kill of all held entries
//   in_valid / in_ready   EX-side handshake (in_ready = skid register empty)
//   in_adder, in_alu      XLEN-bit adder and ALU results
//   in_zero               ALU zero flag
//   in_wdata              XLEN-bit store data
//   in_rd                 destination register index
//   in_ctrl               control bundle {addermuxselect, regwrite, memwrite,
//                         memtoreg, memread, branch}, with branch at bit 0
//   out_valid / out_ready MEM-side handshake
//   out_*                 registered fields; out_ctrl is forced to 0 while
//                         out_valid=0
//   stall_cnt, flush_cnt  saturating event counters (stats build only)
module exmem_stage #(
  parameter int unsigned XLEN   = 64,
  parameter int unsigned RD_W   = 5,
  parameter int unsigned CTRL_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   in_adder,
  input  logic [XLEN-1:0]   in_alu,
  input  logic              in_zero,
  input  logic [XLEN-1:0]   in_wdata,
  input  logic [RD_W-1:0]   in_rd,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_adder,
  output logic [XLEN-1:0]   out_alu,
  output logic [XLEN-1:0]   out_wdata,
  output logic              out_zero,
  output logic [RD_W-1:0]   out_rd,
  output logic [CTRL_W-1:0] out_ctrl
`ifdef EXMEM_STAGE_STATS_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       flush_cnt
`endif
);

  localparam int unsigned EntW = 3 * XLEN + 1 + RD_W + CTRL_W;

  // Main register M drives the outputs; skid register S holds the entry
  // captured while M is stalled.
  logic [EntW-1:0]   r_m_entry;
  logic [EntW-1:0]   r_s_entry;
  logic              r_m_valid;
  logic              r_s_valid;

  logic [EntW-1:0]   w_in_entry;
  logic              w_adv;
  logic              w_accept;
  logic [CTRL_W-1:0] w_m_ctrl;

  assign w_in_entry = {in_adder, in_alu, in_zero, in_wdata, in_rd, in_ctrl};

  // A full skid register is the only reason to refuse input, so in_ready
  // depends only on state and never on out_ready.
  assign in_ready = ~r_s_valid;
  assign w_accept = in_valid & in_ready;
  assign w_adv    = ~r_m_valid | out_ready;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_m_valid <= 1'b0;
      r_s_valid <= 1'b0;
      r_m_entry <= '0;
      r_s_entry <= '0;
    end else if (w_adv && r_s_valid) begin
      // The older skid entry goes first. No input is accepted this cycle
      // because in_ready is low.
      r_m_entry <= r_s_entry;
      r_m_valid <= 1'b1;
      r_s_valid <= 1'b0;
    end else if (w_adv) begin
      // Fields load even for a bubble; out_ctrl gating hides them.
      r_m_entry <= w_in_entry;
      r_m_valid <= in_valid;
    end else if (w_accept) begin
      r_s_entry <= w_in_entry;
      r_s_valid <= 1'b1;
    end
  end

  assign {out_adder, out_alu, out_zero, out_wdata, out_rd, w_m_ctrl} = r_m_entry;
  assign out_valid = r_m_valid;
  // Keep the memwrite and regwrite bits of a bubble from reaching MEM.
  assign out_ctrl  = r_m_valid ? w_m_ctrl : '0;

`ifdef EXMEM_STAGE_STATS_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_flush_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (r_m_valid && !out_ready && (r_stall_cnt != 32'hFFFF_FFFF)) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
      // Count only flushes that actually kill something.
      if (flush && (r_m_valid || r_s_valid) && (r_flush_cnt != 32'hFFFF_FFFF)) begin
        r_flush_cnt <= r_flush_cnt + 32'd1;
      end
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
`endif

endmodule
